// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external-bus sequencer.
package ext_bus_pkg;

  // Sequencer states: address phases, strobe phase, then a turnaround cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Integer ceiling divide, used to size the number of address phases.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ext_bus_wait_timer.sv
// Data-phase timer: counts programmed wait states, then counts stalled
// cycles on the final data cycle and flags a timeout when they run out.
module ext_bus_wait_timer
  import ext_bus_pkg::*;
#(
  parameter int TO_W   = 8,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic              bus_wait,
  output logic              last,
  output logic              done,
  output logic              timeout
);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;

  // Final counted cycle once the programmed wait states are used up.
  assign last    = (wait_cnt_r == {WAIT_W{1'b0}});
  // Normal end: final cycle with the external stall released.
  assign done    = run & last & ~bus_wait;
  // Forced end: the stall counter is exhausted and the stall is still held.
  assign timeout = run & last & bus_wait & (to_cnt_r == {TO_W{1'b1}});

  // Wait-state countdown first, then stall counting on the final cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      to_cnt_r   <= {TO_W{1'b0}};
    end else if (load) begin
      wait_cnt_r <= cfg_wait;
      to_cnt_r   <= {TO_W{1'b0}};
    end else if (run && !last) begin
      wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
    end else if (run && bus_wait) begin
      to_cnt_r   <= to_cnt_r + TO_W'(1);
    end
  end

endmodule

// File: rtl/ext_bus_sequencer.sv
// External-bus master: turns one core request into multiplexed address
// phases followed by a read or write strobe phase on the pad bus.
module ext_bus_sequencer
  import ext_bus_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int ADDR_W      = 32,
  parameter  int WAIT_W      = 4,
  parameter  int TO_W        = 8,
  localparam int ADDR_PHASES = ceil_div(ADDR_W, DATA_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [WAIT_W-1:0]      cfg_wait,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_rdata,
  input  logic [DATA_W-1:0]      bus_din,
  input  logic                   bus_wait,
  output logic [DATA_W-1:0]      bus_dout,
  output logic [ADDR_PHASES-1:0] bus_le,
  output logic                   bus_rw,
  output logic                   bus_rd,
  output logic                   bus_oeb
);

  localparam int PH_W  = (ADDR_PHASES > 1) ? $clog2(ADDR_PHASES) : 1;
  localparam int EXT_W = ADDR_PHASES * DATA_W;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(ADDR_PHASES - 1);

  state_e                 state_r, state_s;
  logic [PH_W-1:0]        phase_r, phase_s;
  logic [EXT_W-1:0]       addr_r, addr_s, req_addr_ext_s;
  logic [DATA_W-1:0]      wdata_r, wdata_s;
  logic                   write_r, write_s;
  logic                   req_ready_r, req_ready_s;
  logic                   rsp_valid_r, rsp_valid_s;
  logic                   rsp_err_r, rsp_err_s;
  logic [DATA_W-1:0]      rsp_rdata_r, rsp_rdata_s;
  logic [DATA_W-1:0]      bus_dout_r, bus_dout_s;
  logic [ADDR_PHASES-1:0] bus_le_r, bus_le_s;
  logic                   bus_rw_r, bus_rw_s;
  logic                   bus_rd_r, bus_rd_s;
  logic                   accept_s, run_s, last_s, done_s, timeout_s;

  assign accept_s = (state_r == IDLE) & req_valid & req_ready_r;
  assign run_s    = (state_r == DATA);

  ext_bus_wait_timer #(
    .TO_W   (TO_W),
    .WAIT_W (WAIT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .run      (run_s),
    .cfg_wait (cfg_wait),
    .bus_wait (bus_wait),
    .last     (last_s),
    .done     (done_s),
    .timeout  (timeout_s)
  );

  // Zero-extend the incoming address to a whole number of bus phases.
  always_comb begin
    req_addr_ext_s               = {EXT_W{1'b0}};
    req_addr_ext_s[ADDR_W-1:0]   = req_addr;
  end

  // Next-state and next-output logic; outputs are registered one stage later.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    write_s     = write_r;
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = rsp_rdata_r;
    bus_dout_s  = bus_dout_r;
    bus_le_s    = {ADDR_PHASES{1'b0}};
    bus_rw_s    = 1'b0;
    bus_rd_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          addr_s      = req_addr_ext_s;
          wdata_s     = req_wdata;
          write_s     = req_write;
          phase_s     = {PH_W{1'b0}};
          bus_le_s[0] = 1'b1;
          bus_dout_s  = req_addr_ext_s[DATA_W-1:0];
          state_s     = ADDR;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ADDR: begin
        if (phase_r == LAST_PH) begin
          state_s = DATA;
          if (write_r) begin
            bus_rw_s   = 1'b1;
            bus_dout_s = wdata_r;
          end else begin
            bus_rd_s   = 1'b1;
          end
        end else begin
          phase_s           = phase_r + PH_W'(1);
          bus_le_s[phase_s] = 1'b1;
          bus_dout_s        = addr_r[int'(phase_s) * DATA_W +: DATA_W];
        end
      end
      DATA: begin
        if (done_s || timeout_s) begin
          state_s     = DONE;
          rsp_valid_s = 1'b1;
          rsp_err_s   = timeout_s;
          // A timed-out read leaves the previous read data in place.
          if (!write_r && last_s && !timeout_s) begin
            rsp_rdata_s = bus_din;
          end else begin
            rsp_rdata_s = rsp_rdata_r;
          end
        end else begin
          bus_rw_s = write_r;
          bus_rd_s = ~write_r;
        end
      end
      DONE: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
    endcase
  end

  // State, capture and output registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      phase_r     <= {PH_W{1'b0}};
      addr_r      <= {EXT_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      write_r     <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      bus_dout_r  <= {DATA_W{1'b0}};
      bus_le_r    <= {ADDR_PHASES{1'b0}};
      bus_rw_r    <= 1'b0;
      bus_rd_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      write_r     <= write_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
      bus_dout_r  <= bus_dout_s;
      bus_le_r    <= bus_le_s;
      bus_rw_r    <= bus_rw_s;
      bus_rd_r    <= bus_rd_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign bus_dout  = bus_dout_r;
  assign bus_le    = bus_le_r;
  assign bus_rw    = bus_rw_r;
  assign bus_rd    = bus_rd_r;
  // Pads drive only while an address phase or a write strobe is active.
  assign bus_oeb   = ~(bus_rw_r | (|bus_le_r));

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Self-checking bench: default 16/32 instance driven from a vector table,
// plus an 8/20 instance for three-phase addressing and back-to-back requests.
module tb_ext_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default instance (DATA_W=16, ADDR_W=32)
  logic        r0_valid, r0_ready, r0_write;
  logic [31:0] r0_addr;
  logic [15:0] r0_wdata;
  logic [3:0]  r0_cfg;
  logic        s0_valid, s0_err;
  logic [15:0] s0_rdata, b0_din, b0_dout;
  logic        b0_wait, b0_rw, b0_rd, b0_oeb;
  logic [1:0]  b0_le;

  // Narrow instance (DATA_W=8, ADDR_W=20)
  logic        r1_valid, r1_ready, r1_write;
  logic [19:0] r1_addr;
  logic [7:0]  r1_wdata;
  logic [3:0]  r1_cfg;
  logic        s1_valid, s1_err;
  logic [7:0]  s1_rdata, b1_din, b1_dout;
  logic        b1_wait, b1_rw, b1_rd, b1_oeb;
  logic [2:0]  b1_le;

  ext_bus_sequencer u0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(r0_ready),
    .req_write(r0_write), .req_addr(r0_addr), .req_wdata(r0_wdata),
    .cfg_wait(r0_cfg), .rsp_valid(s0_valid), .rsp_err(s0_err),
    .rsp_rdata(s0_rdata), .bus_din(b0_din), .bus_wait(b0_wait),
    .bus_dout(b0_dout), .bus_le(b0_le), .bus_rw(b0_rw), .bus_rd(b0_rd),
    .bus_oeb(b0_oeb)
  );

  ext_bus_sequencer #(.DATA_W(8), .ADDR_W(20)) u1 (
    .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_write(r1_write), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .cfg_wait(r1_cfg), .rsp_valid(s1_valid), .rsp_err(s1_err),
    .rsp_rdata(s1_rdata), .bus_din(b1_din), .bus_wait(b1_wait),
    .bus_dout(b1_dout), .bus_le(b1_le), .bus_rw(b1_rw), .bus_rd(b1_rd),
    .bus_oeb(b1_oeb)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [3:0]  cfg;
    logic [15:0] din;
    int          stall;       // strobe cycles (from the first) with bus_wait high
    int          exp_strobe;  // strobe cycles expected
    int          exp_rsp;     // negedge index of rsp_valid after accept edge
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_u0(input vec_t v, input int idx);
    int rsp_n, strobe_n, oeb_low, excl_bad, rv_cnt, dout_bad, acc;
    logic [1:0]  le1, le2;
    logic [15:0] d1, d2, rdata_at;
    logic        err_at, ready_after;
    string       tag;
    tag = $sformatf("v%0d", idx);
    rsp_n = 0; strobe_n = 0; oeb_low = 0; excl_bad = 0; rv_cnt = 0; dout_bad = 0; acc = 0;
    le1 = '0; le2 = '0; d1 = '0; d2 = '0; rdata_at = '0; err_at = 1'b0; ready_after = 1'b0;
    @(negedge clk);
    r0_valid = 1'b1; r0_write = v.write; r0_addr = v.addr; r0_wdata = v.wdata;
    r0_cfg = v.cfg; b0_wait = 1'b0; b0_din = ~v.din;
    for (int i = 0; i < 10 && acc == 0; i++) begin
      if (r0_ready) acc = 1;
      else @(negedge clk);
    end
    chk({tag, "_accept"}, 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    r0_cfg   = ~v.cfg;   // must not affect the transaction in flight
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) begin le1 = b0_le; d1 = b0_dout; end
      if (n == 2) begin le2 = b0_le; d2 = b0_dout; end
      if (!b0_oeb) oeb_low++;
      if (int'(|b0_le) + int'(b0_rw) + int'(b0_rd) > 1) excl_bad++;
      if (b0_rw || b0_rd) begin
        strobe_n++;
        if (b0_rw != v.write || b0_rd != !v.write) dout_bad++;
        if (v.write && b0_dout != v.wdata) dout_bad++;
      end
      if (s0_valid) begin
        rv_cnt++;
        if (rsp_n == 0) begin rsp_n = n; err_at = s0_err; rdata_at = s0_rdata; end
      end
      b0_wait = (b0_rw || b0_rd) && (strobe_n <= v.stall);
      b0_din  = ((b0_rw || b0_rd) && strobe_n == v.exp_strobe) ? v.din : ~v.din;
      if (rsp_n != 0 && n == rsp_n + 1) begin
        ready_after = r0_ready;
        break;
      end
    end
    b0_wait = 1'b0;
    chk({tag, "_phase0"}, 64'({le1, d1}), 64'({2'b01, v.addr[15:0]}));
    chk({tag, "_phase1"}, 64'({le2, d2}), 64'({2'b10, v.addr[31:16]}));
    chk({tag, "_strobe_len"}, 64'(strobe_n), 64'(v.exp_strobe));
    chk({tag, "_strobe_data"}, 64'(dout_bad), 64'd0);
    chk({tag, "_exclusive"}, 64'(excl_bad), 64'd0);
    chk({tag, "_oeb_low"}, 64'(oeb_low), 64'(v.write ? 2 + v.exp_strobe : 2));
    chk({tag, "_rsp_latency"}, 64'(rsp_n), 64'(v.exp_rsp));
    chk({tag, "_rsp_err"}, 64'(err_at), 64'(v.exp_err));
    chk({tag, "_rsp_rdata"}, 64'(rdata_at), 64'(v.exp_rdata));
    chk({tag, "_rsp_pulse"}, 64'(rv_cnt), 64'd1);
    chk({tag, "_ready_after"}, 64'(ready_after), 64'd1);
  endtask

  function automatic int cl(input int i);
    return (i > 39) ? 39 : ((i < 0) ? 0 : i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rv_seen, k, m, a, b;
    int acc_c[2];
    int rsp_c[2];
    logic [2:0] le_log[40];
    logic [7:0] dout_log[40];
    logic [7:0] rdata_at[2];

    vecs[0] = '{1'b1, 32'h1234ABCD, 16'hBEEF, 4'd0, 16'h0000, 0,   1,   4,   1'b0, 16'h0000};
    vecs[1] = '{1'b0, 32'h00000010, 16'h0000, 4'd3, 16'h5A5A, 0,   4,   7,   1'b0, 16'h5A5A};
    vecs[2] = '{1'b0, 32'h00C0FFEE, 16'h0000, 4'd0, 16'h1357, 5,   6,   9,   1'b0, 16'h1357};
    vecs[3] = '{1'b0, 32'hDEAD0000, 16'h0000, 4'd0, 16'h2222, 300, 256, 259, 1'b1, 16'h1357};
    vecs[4] = '{1'b0, 32'h00000004, 16'h0000, 4'd2, 16'h2468, 2,   3,   6,   1'b0, 16'h2468};
    vecs[5] = '{1'b1, 32'hFFFF0001, 16'h0F0F, 4'd1, 16'h0000, 3,   4,   7,   1'b0, 16'h2468};

    rst = 1'b1;
    r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0; r0_cfg = '0;
    b0_din = '0; b0_wait = 1'b0;
    r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0; r1_cfg = '0;
    b1_din = '0; b1_wait = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_u0", 64'({r0_ready, s0_valid, s0_err, s0_rdata, b0_dout, b0_le, b0_rw, b0_rd, b0_oeb}),
        64'({1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1}));
    chk("reset_u1", 64'({r1_ready, s1_valid, s1_err, s1_rdata, b1_dout, b1_le, b1_rw, b1_rd, b1_oeb}),
        64'({1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 3'b000, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;

    // Reset in the middle of address phase 1 aborts without a response.
    @(negedge clk);
    r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 32'h1234ABCD; r0_wdata = 16'hBEEF; r0_cfg = 4'd0;
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_pre", 64'({b0_le, b0_dout}), 64'({2'b10, 16'h1234}));
    rst = 1'b1;
    #1;
    chk("abort_async", 64'({r0_ready, s0_valid, s0_err, b0_dout, b0_le, b0_rw, b0_rd, b0_oeb}),
        64'({1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s0_valid) rv_seen++;
    end
    chk("abort_no_rsp", 64'(rv_seen), 64'd0);

    for (int i = 0; i < 6; i++) run_u0(vecs[i], i);

    // Narrow instance: three address phases and back-to-back requests.
    k = 0; m = 0;
    acc_c[0] = 0; acc_c[1] = 0; rsp_c[0] = 0; rsp_c[1] = 0;
    rdata_at[0] = '0; rdata_at[1] = '0;
    @(negedge clk);
    r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 20'hABCDE; r1_wdata = 8'h5C; r1_cfg = 4'd0;
    b1_din = 8'h77; b1_wait = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      le_log[c] = b1_le;
      dout_log[c] = b1_dout;
      if (s1_valid && m < 2) begin rsp_c[m] = c; rdata_at[m] = s1_rdata; m++; end
      if (r1_valid && r1_ready && k < 2) begin
        acc_c[k] = c;
        k++;
      end else if (k == 1) begin
        r1_write = 1'b0; r1_addr = 20'h12345; r1_cfg = 4'd1;
      end else if (k == 2) begin
        r1_valid = 1'b0;
      end
    end
    r1_valid = 1'b0;
    a = acc_c[0];
    b = acc_c[1];
    chk("n_a_phase0", 64'({le_log[cl(a + 1)], dout_log[cl(a + 1)]}), 64'({3'b001, 8'hDE}));
    chk("n_a_phase1", 64'({le_log[cl(a + 2)], dout_log[cl(a + 2)]}), 64'({3'b010, 8'hBC}));
    chk("n_a_phase2", 64'({le_log[cl(a + 3)], dout_log[cl(a + 3)]}), 64'({3'b100, 8'h0A}));
    chk("n_a_wdata", 64'({le_log[cl(a + 4)], dout_log[cl(a + 4)]}), 64'({3'b000, 8'h5C}));
    chk("n_a_latency", 64'(rsp_c[0] - a), 64'd5);
    chk("n_b2b_accept", 64'(b - rsp_c[0]), 64'd1);
    chk("n_b_phase2", 64'({le_log[cl(b + 3)], dout_log[cl(b + 3)]}), 64'({3'b100, 8'h01}));
    chk("n_b_latency", 64'(rsp_c[1] - b), 64'd6);
    chk("n_b_rdata", 64'(rdata_at[1]), 64'(8'h77));
    chk("n_rsp_count", 64'(m), 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
